// File: rtl/conv_window_buffer.sv
// Streaming 5x5 sliding-window generator: raster-order pixels in, one registered
// 5x5 window per valid (unpadded) output position out, valid/ready on both sides.
module conv_window_buffer #(
    parameter int bitwidth = 16,
    parameter int IMG_W    = 28,
    parameter int IMG_H    = 28
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [bitwidth-1:0] in_pixel,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [bitwidth-1:0] map_block [4:0][4:0],
    output logic                       out_last
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic [CW-1:0] col_reg, col_next, rd_addr;
    logic [RW-1:0] row_reg, row_next;
    logic          accept, col_wrap, row_wrap;
    logic          out_valid_reg, out_last_reg;
    logic signed [bitwidth-1:0] win_reg [4:0][4:0];
    // taps slice k holds row r-1-k at the column of the next pixel to be accepted
    logic [4*bitwidth-1:0] taps;

    assign in_ready = !out_valid_reg || out_ready;
    assign accept   = in_valid && in_ready;
    assign col_wrap = (col_reg == CW'(IMG_W - 1));
    assign row_wrap = (row_reg == RW'(IMG_H - 1));

    always_comb begin
        col_next = col_reg;
        row_next = row_reg;
        if (accept) begin
            if (col_wrap) begin
                col_next = '0;
                row_next = row_wrap ? '0 : row_reg + RW'(1);
            end else begin
                col_next = col_reg + CW'(1);
            end
        end
    end

    // Read one column ahead so the registered RAM output is ready at the accept
    // edge; the address being read is never the one being written that cycle.
    assign rd_addr = reset ? '0 : col_next;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_line
            logic signed [bitwidth-1:0] mem [IMG_W];
            logic signed [bitwidth-1:0] rd_reg;
            logic signed [bitwidth-1:0] wr_data;

            if (gi == 0) begin : g_head
                assign wr_data = in_pixel;
            end else begin : g_chain
                assign wr_data = taps[(gi-1)*bitwidth +: bitwidth];
            end

            always_ff @(posedge clk) begin
                if (accept) begin
                    mem[col_reg] <= wr_data;
                end
                rd_reg <= mem[rd_addr];
            end

            assign taps[gi*bitwidth +: bitwidth] = rd_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            col_reg       <= '0;
            row_reg       <= '0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            for (int i = 0; i < 5; i++) begin
                for (int j = 0; j < 5; j++) begin
                    win_reg[i][j] <= '0;
                end
            end
        end else begin
            col_reg <= col_next;
            row_reg <= row_next;
            if (accept) begin
                for (int i = 0; i < 5; i++) begin
                    for (int j = 0; j < 4; j++) begin
                        win_reg[i][j] <= win_reg[i][j+1];
                    end
                end
                win_reg[4][4] <= in_pixel;
                for (int i = 0; i < 4; i++) begin
                    win_reg[i][4] <= taps[(3-i)*bitwidth +: bitwidth];
                end
                out_valid_reg <= (row_reg >= RW'(4)) && (col_reg >= CW'(4));
                out_last_reg  <= row_wrap && col_wrap;
            end else if (out_valid_reg && out_ready) begin
                out_valid_reg <= 1'b0;
                out_last_reg  <= 1'b0;
            end
        end
    end

    assign map_block = win_reg;
    assign out_valid = out_valid_reg;
    assign out_last  = out_last_reg;

endmodule

// File: doc/conv_window_buffer.md
Name: conv_window_buffer

Overview:
- Streaming 5x5 sliding-window generator directly upstream of the 5x5 convolution point.
- Accepts feature-map pixels one per cycle in raster order (row-major, top-left first) and keeps the last 4 rows in line buffers.
- Presents a registered 5x5 map_block for every valid (no-padding) output position, with a valid/ready handshake.
- For an IMG_W x IMG_H map it emits (IMG_W-4) x (IMG_H-4) windows per frame.

Parameters:
- bitwidth, 16, signed pixel width; must match the convolution stage.
- IMG_W, 28, pixels per row; legal range is 5 or more.
- IMG_H, 28, rows per frame; legal range is 5 or more.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  in_pixel is presented this cycle.
- in_ready  output  1  block can accept in_pixel this cycle.
- in_pixel  input  signed bitwidth  next raster-order pixel.
- out_valid  output  1  map_block holds a complete window.
- out_ready  input  1  downstream consumes map_block this cycle.
- map_block  output  signed bitwidth, array [4:0][4:0]  current window.
  - Index [i][j]: i = row, 0 = top/oldest. j = column, 0 = leftmost.
- out_last  output  1  qualifies out_valid: this is the final window of the frame.

Behaviour:
- Handshakes:
  - Input accept when in_valid && in_ready.
  - in_ready = !out_valid || out_ready (single output slot; combinational from out_ready).
  - Output transfer when out_valid && out_ready.
- Counters: col (0..IMG_W-1) and row (0..IMG_H-1) give the position of the next pixel to be accepted.
  - On each accept, col increments. At IMG_W-1, col wraps to 0 and row increments.
  - At row IMG_H-1, col IMG_W-1, both wrap to 0; the next pixel starts a new frame.
- Line buffers: 4 buffers, each IMG_W deep, hold rows r-1..r-4 at column c.
  - On accept of pixel (r,c), map_block shifts left: [i][j] <= [i][j+1] for j=0..3.
  - New column: [4][4] <= in_pixel; [3][4] <= row r-1 col c; [2][4] <= row r-2; [1][4] <= row r-3; [0][4] <= row r-4.
  - Buffers are then updated so the taps advance by one row.
  - Buffer reads at column c must return data written at column c one row earlier, not the same-cycle write.
- Output:
  - On accept, out_valid <= (r>=4 && c>=4) and out_last <= (r==IMG_H-1 && c==IMG_W-1).
  - Else, if an output transfer occurs, out_valid <= 0 and out_last <= 0.
  - Latency: the window is visible 1 cycle after the accepting edge of its bottom-right pixel.
- Stall: while out_valid && !out_ready, in_ready = 0 and map_block, counters, buffers and out_valid all hold.
- Simultaneous output transfer and input accept in the same cycle: the new window (or out_valid=0) replaces the old one. No bubble is required.
- Windows never straddle rows: out_valid requires c>=4, so stale left-edge columns are never exposed.
- Pixel arithmetic: pure data movement, no width change, sign preserved bit-exact.
- Reset values:
  - out_valid=0, out_last=0, map_block all 0, row=0, col=0.
  - in_ready=1 after reset (follows from out_valid=0).
  - Line buffer contents are not reset; they are never observable before they are rewritten in the current frame.
- Reset mid-frame: the partial frame is discarded and the next accepted pixel is (0,0). No window from the aborted frame may appear after reset.
- in_valid low: no state change. Gaps between pixels do not affect results.

Test Plan:
- Default 28x28, in_pixel = 28r+c, out_ready=1, in_valid=1 every cycle:
  - exactly 576 windows;
  - the first appears the cycle after pixel 116, with map_block[0][0]=0, [0][4]=4, [4][0]=112, [4][4]=116;
  - the last has [4][4]=783, [0][0]=667 and out_last=1, the only out_last in the frame.
- Backpressure: out_ready toggles with a random 50% pattern on the same frame:
  - identical 576-window sequence;
  - in_ready=0 on every cycle with out_valid=1 and out_ready=0;
  - no pixel lost or duplicated.
- Minimum config IMG_W=IMG_H=5, pixels 0..24 -> exactly one window, map_block[i][j]=5i+j, out_last=1.
- Signed data: IMG_W=IMG_H=5, all pixels 16'h8000 (bitwidth=16) -> window entries all equal -32768.
- Reset mid-frame: reset after 100 pixels of a 28x28 frame, then a full fresh frame -> exactly 576 windows matching the first scenario, none earlier.
- Back-to-back frames with random in_valid gaps -> 2x576 windows, second-frame first window [0][0]=0 (new frame values), out_last exactly twice.
